// File: rtl/blc_correction.sv
// Black-level correction: per-lane offset subtract with zero clamp, then Q2.10 gain with rounding/saturation.
// Latency: 2 cycles from input acceptance to O_tvalid, one beat per cycle.
// Backpressure: both stages stall together; I_tready = !O_tvalid | O_tready.
module blc_correction #(
   parameter int DATA_W = 10,
   parameter int LANES  = 4,
   parameter int GAIN_W = 12,
   parameter int CNT_W  = 21
) (
   input  logic                      I_clk,
   input  logic                      I_rst_n,
   input  logic [DATA_W*LANES-1:0]   I_tdata,
   input  logic                      I_tvalid,
   input  logic                      I_tuser,
   input  logic                      I_tlast,
   output logic                      I_tready,
   output logic [DATA_W*LANES-1:0]   O_tdata,
   output logic                      O_tvalid,
   output logic                      O_tuser,
   output logic                      O_tlast,
   input  logic                      O_tready,
   input  logic [DATA_W-1:0]         I_offset_r0,
   input  logic [DATA_W-1:0]         I_offset_r1,
   input  logic [DATA_W-1:0]         I_offset_r2,
   input  logic [DATA_W-1:0]         I_offset_r3,
   input  logic [GAIN_W-1:0]         I_gain_r0,
   input  logic [GAIN_W-1:0]         I_gain_r1,
   input  logic [GAIN_W-1:0]         I_gain_r2,
   input  logic [GAIN_W-1:0]         I_gain_r3,
   input  logic                      I_bypass,
   output logic [CNT_W-1:0]          O_clip_count
);

   localparam int TW   = DATA_W * LANES;
   localparam int GW   = GAIN_W * LANES;
   localparam int PW   = DATA_W + GAIN_W;
   localparam int FRAC = GAIN_W - 2;
   localparam logic [PW:0]       RND   = (PW+1)'(1 << (FRAC - 1));
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << FRAC);

   logic          advance, acc_beat, sof_beat;
   logic [TW-1:0] off_in;
   logic [GW-1:0] gain_in;

   logic [TW-1:0] off_sh_q, off_sh_d;
   logic [GW-1:0] gain_sh_q, gain_sh_d;
   logic          byp_sh_q, byp_sh_d;

   logic          s1_vld_q, s1_vld_d, s1_user_q, s1_user_d, s1_last_q, s1_last_d;
   logic          s1_byp_q, s1_byp_d;
   logic [TW-1:0] s1_dat_q, s1_dat_d;
   logic [GW-1:0] s1_gain_q, s1_gain_d;
   logic [LANES-1:0] clip;

   logic          o_vld_q, o_vld_d, o_user_q, o_user_d, o_last_q, o_last_d;
   logic [TW-1:0] o_dat_q, o_dat_d;

   logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
   logic [CNT_W:0]   pop, acc_sum;

   // Handshake: one global advance for both stages
   assign advance  = !o_vld_q | O_tready;
   assign I_tready = advance;
   assign acc_beat = I_tvalid & advance;
   assign sof_beat = acc_beat & I_tuser;
   assign off_in   = {I_offset_r3, I_offset_r2, I_offset_r1, I_offset_r0};
   assign gain_in  = {I_gain_r3, I_gain_r2, I_gain_r1, I_gain_r0};

   // Shadow config: captured on a start-of-frame beat; _d is also the value that beat uses
   always_comb begin
      off_sh_d  = off_sh_q;
      gain_sh_d = gain_sh_q;
      byp_sh_d  = byp_sh_q;
      if (sof_beat) begin
         off_sh_d  = off_in;
         gain_sh_d = gain_in;
         byp_sh_d  = I_bypass;
      end
   end

   // Stage 1: offset subtract with zero clamp; gain and bypass travel with the beat
   always_comb begin : s1_calc
      logic [DATA_W-1:0] x, o, d;
      s1_vld_d  = s1_vld_q;
      s1_user_d = s1_user_q;
      s1_last_d = s1_last_q;
      s1_byp_d  = s1_byp_q;
      s1_dat_d  = s1_dat_q;
      s1_gain_d = s1_gain_q;
      clip      = '0;
      for (int k = 0; k < LANES; k++) begin
         x = I_tdata[k*DATA_W +: DATA_W];
         o = off_sh_d[k*DATA_W +: DATA_W];
         if (byp_sh_d) begin
            d = x;
         end else if (x < o) begin
            d       = '0;
            clip[k] = 1'b1;
         end else begin
            d = x - o;
         end
         if (advance) s1_dat_d[k*DATA_W +: DATA_W] = d;
      end
      if (advance) begin
         s1_vld_d  = I_tvalid;
         s1_user_d = I_tuser;
         s1_last_d = I_tlast;
         s1_byp_d  = byp_sh_d;
         s1_gain_d = gain_sh_d;
      end
   end

   // Stage 2: multiply, round half up, saturate to full scale
   always_comb begin : s2_calc
      logic [PW:0] prod;
      o_vld_d  = o_vld_q;
      o_user_d = o_user_q;
      o_last_d = o_last_q;
      o_dat_d  = o_dat_q;
      for (int k = 0; k < LANES; k++) begin
         prod = (PW+1)'(s1_dat_q[k*DATA_W +: DATA_W]) * (PW+1)'(s1_gain_q[k*GAIN_W +: GAIN_W]) + RND;
         if (advance) begin
            if (s1_byp_q)
               o_dat_d[k*DATA_W +: DATA_W] = s1_dat_q[k*DATA_W +: DATA_W];
            else if (|prod[PW:FRAC+DATA_W])
               o_dat_d[k*DATA_W +: DATA_W] = '1;
            else
               o_dat_d[k*DATA_W +: DATA_W] = prod[FRAC+DATA_W-1:FRAC];
         end
      end
      if (advance) begin
         o_vld_d  = s1_vld_q;
         o_user_d = s1_user_q;
         o_last_d = s1_last_q;
      end
   end

   // Clip accounting: publish at each frame start, restart with that beat's clips
   always_comb begin
      pop = '0;
      for (int k = 0; k < LANES; k++) pop = pop + (CNT_W+1)'(clip[k]);
      acc_sum = {1'b0, acc_q} + pop;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (sof_beat) begin
         cnt_d = acc_q;
         acc_d = pop[CNT_W-1:0];
      end else if (acc_beat) begin
         acc_d = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         off_sh_q  <= '0;
         gain_sh_q <= {LANES{UNITY}};
         byp_sh_q  <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_user_q <= 1'b0;
         s1_last_q <= 1'b0;
         s1_byp_q  <= 1'b0;
         s1_dat_q  <= '0;
         s1_gain_q <= {LANES{UNITY}};
         o_vld_q   <= 1'b0;
         o_user_q  <= 1'b0;
         o_last_q  <= 1'b0;
         o_dat_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
      end else begin
         off_sh_q  <= off_sh_d;
         gain_sh_q <= gain_sh_d;
         byp_sh_q  <= byp_sh_d;
         s1_vld_q  <= s1_vld_d;
         s1_user_q <= s1_user_d;
         s1_last_q <= s1_last_d;
         s1_byp_q  <= s1_byp_d;
         s1_dat_q  <= s1_dat_d;
         s1_gain_q <= s1_gain_d;
         o_vld_q   <= o_vld_d;
         o_user_q  <= o_user_d;
         o_last_q  <= o_last_d;
         o_dat_q   <= o_dat_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
      end
   end

   assign O_tdata      = o_dat_q;
   assign O_tvalid     = o_vld_q;
   assign O_tuser      = o_user_q;
   assign O_tlast      = o_last_q;
   assign O_clip_count = cnt_q;

endmodule

// File: tb/tb_blc_correction.sv
// Directed bench for blc_correction: vector table streamed at full rate, then
// backpressure, bypass and mid-frame reset sequences.
module tb_blc_correction;

   logic        I_clk = 1'b0;
   logic        I_rst_n;
   logic [39:0] I_tdata;
   logic        I_tvalid, I_tuser, I_tlast, I_tready;
   logic [39:0] O_tdata;
   logic        O_tvalid, O_tuser, O_tlast, O_tready;
   logic [9:0]  I_offset_r0, I_offset_r1, I_offset_r2, I_offset_r3;
   logic [11:0] I_gain_r0, I_gain_r1, I_gain_r2, I_gain_r3;
   logic        I_bypass;
   logic [20:0] O_clip_count;

   always #5 I_clk = ~I_clk;

   blc_correction dut (
      .I_clk(I_clk), .I_rst_n(I_rst_n),
      .I_tdata(I_tdata), .I_tvalid(I_tvalid), .I_tuser(I_tuser), .I_tlast(I_tlast), .I_tready(I_tready),
      .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tuser(O_tuser), .O_tlast(O_tlast), .O_tready(O_tready),
      .I_offset_r0(I_offset_r0), .I_offset_r1(I_offset_r1), .I_offset_r2(I_offset_r2), .I_offset_r3(I_offset_r3),
      .I_gain_r0(I_gain_r0), .I_gain_r1(I_gain_r1), .I_gain_r2(I_gain_r2), .I_gain_r3(I_gain_r3),
      .I_bypass(I_bypass), .O_clip_count(O_clip_count)
   );

   typedef struct {
      logic [39:0] dat;
      logic        usr;
      logic        lst;
      logic [39:0] off;
      logic [47:0] gn;
      logic        byp;
      logic [39:0] exp_dat;
      logic [20:0] exp_clip;   // O_clip_count right after this beat is accepted
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];
   int pass_cnt = 0;
   int total    = 0;

   function automatic logic [39:0] p4(int a, int b, int c, int d);
      return {10'(d), 10'(c), 10'(b), 10'(a)};
   endfunction

   function automatic logic [47:0] g4(int a, int b, int c, int d);
      return {12'(d), 12'(c), 12'(b), 12'(a)};
   endfunction

   function automatic vec_t mk(logic [39:0] dat, logic usr, logic lst, logic [39:0] off,
                               logic [47:0] gn, logic byp, logic [39:0] ed, int ec);
      vec_t v;
      v.dat = dat; v.usr = usr; v.lst = lst; v.off = off; v.gn = gn; v.byp = byp;
      v.exp_dat = ed; v.exp_clip = 21'(ec);
      return v;
   endfunction

   function automatic logic [39:0] pat(int i);
      return p4((4*i) % 1024, (4*i+1) % 1024, (4*i+2) % 1024, (4*i+3) % 1024);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic set_cfg(logic [39:0] off, logic [47:0] gn, logic byp);
      I_offset_r0 = off[9:0];   I_offset_r1 = off[19:10];
      I_offset_r2 = off[29:20]; I_offset_r3 = off[39:30];
      I_gain_r0 = gn[11:0];     I_gain_r1 = gn[23:12];
      I_gain_r2 = gn[35:24];    I_gain_r3 = gn[47:36];
      I_bypass  = byp;
   endtask

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   initial begin
      logic [39:0] held;
      logic        stalled_prev, fire_in, fire_out;
      int          in_idx, out_idx, stall_cyc;

      //               data                     usr  lst  offsets             gains                         byp  expected                  clip
      vecs[0]  = mk(p4(100,64,10,1023),        1, 0, p4(64,64,64,64),    g4(1024,1024,1024,1024), 0, p4(36,0,0,959),       0);
      vecs[1]  = mk(p4(63,200,64,65),          0, 1, p4(64,64,64,64),    g4(1024,1024,1024,1024), 0, p4(0,136,0,1),        0);
      vecs[2]  = mk(p4(1023,564,64,0),         1, 0, p4(64,64,64,64),    g4(1092,1092,1092,1092), 0, p4(1023,533,0,0),     2);
      vecs[3]  = mk(p4(100,564,1023,70),       0, 1, p4(100,64,64,64),   g4(1092,1092,1092,1092), 0, p4(38,533,1023,6),    2);
      vecs[4]  = mk(p4(100,564,99,1023),       1, 0, p4(100,64,64,64),   g4(1092,1092,1092,1092), 0, p4(0,533,37,1023),    1);
      vecs[5]  = mk(p4(50,0,5,1023),           0, 1, p4(100,64,64,64),   g4(1092,1092,1092,1092), 0, p4(0,0,0,1023),       1);
      vecs[6]  = mk(p4(500,777,1023,301),      1, 0, p4(0,0,0,0),        g4(0,1024,4095,1536),    0, p4(0,777,1023,452),   3);
      vecs[7]  = mk(p4(1,2,3,4),               0, 1, p4(0,0,0,0),        g4(0,1024,4095,1536),    1, p4(0,2,12,6),         3);
      vecs[8]  = mk(p4(5,1000,0,63),           1, 0, p4(64,64,64,64),    g4(1092,1092,1092,1092), 1, p4(5,1000,0,63),      0);
      vecs[9]  = mk(p4(10,20,30,1023),         0, 1, p4(64,64,64,64),    g4(1092,1092,1092,1092), 0, p4(10,20,30,1023),    0);
      vecs[10] = mk(p4(0,1,512,1023),          1, 0, p4(0,0,0,0),        g4(1024,1024,1024,1024), 0, p4(0,1,512,1023),     0);
      vecs[11] = mk(p4(7,8,9,10),              0, 1, p4(0,0,0,0),        g4(1024,1024,1024,1024), 0, p4(7,8,9,10),         0);
      vecs[12] = mk(p4(1022,1023,0,500),       1, 1, p4(1023,1023,1023,1023), g4(1024,1024,1024,1024), 0, p4(0,0,0,0),     0);
      vecs[13] = mk(p4(1,1,1,1),               1, 1, p4(0,0,0,0),        g4(1024,1024,1024,1024), 0, p4(1,1,1,1),          3);

      // Reset state
      I_rst_n = 1'b0; I_tvalid = 1'b0; I_tuser = 1'b0; I_tlast = 1'b0; I_tdata = '0; O_tready = 1'b1;
      set_cfg(p4(0,0,0,0), g4(1024,1024,1024,1024), 1'b0);
      step(); step();
      chk("rst_tvalid", O_tvalid, 0);
      chk("rst_tdata", O_tdata, 0);
      chk("rst_tuser", O_tuser, 0);
      chk("rst_clip", O_clip_count, 0);
      chk("rst_tready", I_tready, 1);
      I_rst_n = 1'b1;
      step();

      // Vector table streamed back to back with O_tready high
      for (int n = 0; n <= NV + 1; n++) begin
         if (n < NV) begin
            I_tvalid = 1'b1; I_tdata = vecs[n].dat; I_tuser = vecs[n].usr; I_tlast = vecs[n].lst;
            set_cfg(vecs[n].off, vecs[n].gn, vecs[n].byp);
         end else begin
            I_tvalid = 1'b0; I_tuser = 1'b0; I_tlast = 1'b0;
         end
         step();
         if (n < NV) chk($sformatf("vec%0d_clip", n), O_clip_count, vecs[n].exp_clip);
         if (n >= 1 && n <= NV) begin
            chk($sformatf("vec%0d_vld", n-1), O_tvalid, 1);
            chk($sformatf("vec%0d_dat", n-1), O_tdata, vecs[n-1].exp_dat);
            chk($sformatf("vec%0d_usr", n-1), O_tuser, vecs[n-1].usr);
            chk($sformatf("vec%0d_lst", n-1), O_tlast, vecs[n-1].lst);
         end
         if (n == NV + 1) chk("vec_drain_vld", O_tvalid, 0);
      end

      // Backpressure: 100 beats, downstream stalls for 5 cycles
      set_cfg(p4(0,0,0,0), g4(1024,1024,1024,1024), 1'b0);
      in_idx = 0; out_idx = 0; stall_cyc = 0; stalled_prev = 1'b0; held = '0;
      for (int cyc = 0; cyc < 400 && out_idx < 100; cyc++) begin
         I_tvalid = (in_idx < 100);
         I_tdata  = pat(in_idx);
         I_tuser  = (in_idx == 0);
         I_tlast  = (in_idx % 10 == 9);
         O_tready = !(cyc >= 20 && cyc < 25);
         #1;
         if (O_tvalid && !O_tready) begin
            stall_cyc++;
            chk("bp_stall_tready", I_tready, 0);
            if (stalled_prev) chk("bp_stall_hold", O_tdata, held);
            held = O_tdata;
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         fire_in  = I_tvalid & I_tready;
         fire_out = O_tvalid & O_tready;
         if (fire_out) begin
            chk($sformatf("bp_dat%0d", out_idx), O_tdata, pat(out_idx));
            chk($sformatf("bp_lst%0d", out_idx), O_tlast, (out_idx % 10 == 9));
            out_idx++;
         end
         @(posedge I_clk);
         #1;
         if (fire_in) in_idx++;
      end
      chk("bp_out_count", out_idx, 100);
      chk("bp_stall_cycles", stall_cyc, 5);
      I_tvalid = 1'b0; I_tuser = 1'b0; I_tlast = 1'b0; O_tready = 1'b1;
      step();
      chk("bp_no_extra", O_tvalid, 0);

      // Mid-frame reset with two beats in flight
      set_cfg(p4(0,0,0,0), g4(2048,2048,2048,2048), 1'b0);
      I_tvalid = 1'b1; I_tuser = 1'b1; I_tdata = p4(100,50,1,0);
      step();
      I_tuser = 1'b0; I_tdata = p4(7,7,7,7);
      step();
      chk("rst_pre_vld", O_tvalid, 1);
      chk("rst_pre_dat", O_tdata, p4(200,100,2,0));
      I_tvalid = 1'b0; I_rst_n = 1'b0;
      step();
      chk("rst_mid_vld", O_tvalid, 0);
      chk("rst_mid_dat", O_tdata, 0);
      I_rst_n = 1'b1;
      step();
      chk("rst_post_vld0", O_tvalid, 0);
      step();
      chk("rst_post_vld1", O_tvalid, 0);
      I_tvalid = 1'b1; I_tuser = 1'b0; I_tdata = p4(300,1,2,3);
      step();
      I_tvalid = 1'b0;
      step();
      chk("rst_gain_vld", O_tvalid, 1);
      chk("rst_gain_unity", O_tdata, p4(300,1,2,3));
      chk("rst_gain_clip", O_clip_count, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/blc_correction.md
Name: blc_correction

Overview:
- Black-level correction stage fed by the same 4-pixel-per-beat RAW AXI-Stream that the BLC measurement block taps.
- Per lane: subtracts a per-channel black-level offset and clamps the result at zero. Then applies a per-channel gain that restores full range, with rounding and saturation.
- Offsets/gains normally come from the measurement block's black_level_offset_r0..r3 outputs and a register file. They are frame-synchronised so they never change mid-frame.
- Also reports the number of zero-clamped samples per frame.

Parameters:
- DATA_W, 10, bits per pixel lane.
- LANES, 4, pixels per beat; tdata width = DATA_W*LANES.
- GAIN_W, 12, gain width, unsigned Q2.10; 1024 = unity.
- CNT_W, 21, clip counter width.

Ports:
- I_clk  in  1  clock.
- I_rst_n  in  1  reset; synchronous, active-low.
- I_tdata  in  40  lane k = bits [10k+9:10k].
- I_tvalid  in  1  input beat valid.
- I_tuser  in  1  start of frame, first beat.
- I_tlast  in  1  end of line.
- I_tready  out  1  input ready.
- O_tdata  out  40  corrected pixels, same lane packing.
- O_tvalid  out  1  output beat valid.
- O_tuser  out  1  delayed I_tuser.
- O_tlast  out  1  delayed I_tlast.
- O_tready  in  1  downstream ready.
- I_offset_r0..I_offset_r3  in  10 each  per-lane black-level offset.
- I_gain_r0..I_gain_r3  in  12 each  per-lane gain, Q2.10.
- I_bypass  in  1  1 = pass data unmodified.
- O_clip_count  out  21  zero-clamped lane count of the previous complete frame.

Behaviour:
- Reset: synchronous on I_clk when I_rst_n=0. All pipeline valids, O_tvalid, O_tuser, O_tlast, O_tdata and O_clip_count = 0. Shadow offsets = 0, shadow gains = 1024, shadow bypass = 0. Internal clip accumulator = 0. Reset mid-frame discards in-flight beats; nothing is emitted for them.
- Handshake: beat accepted when I_tvalid & I_tready. 2-stage elastic pipeline; advance = !O_tvalid | O_tready; I_tready = advance. I_tready is combinational from O_tready and O_tvalid only. O_tdata, O_tuser and O_tlast are held stable while O_tvalid & !O_tready. No beat is dropped or duplicated.
- Latency: 2 cycles from acceptance to O_tvalid when O_tready stays high. Full throughput, one beat per cycle.
- Shadowing: on an accepted beat with I_tuser=1, capture I_offset_*, I_gain_* and I_bypass into shadow registers. That beat and all later beats up to the next tuser beat use the new values. Port changes with no tuser beat have no effect.
- Stage 1, per lane: d = x - off. If x < off then d = 0 and the lane is counted as clipped. d is DATA_W bits.
- Stage 2, per lane: p = d*gain (22 bits). r = (p + 512) >> 10. If r > 1023, output 1023; otherwise output r[9:0].
- Bypass: output lane = input lane; latency unchanged; no clips counted.
- Sideband: tuser and tlast travel in lockstep with their beat through both stages.
- Clip counter: the accumulator adds popcount(clip flags of the beat), 0..4, per stage-1 advance. It saturates at 2^CNT_W-1.
- On stage-1 advance of a tuser beat: O_clip_count <= accumulator value (frame just ended), and the accumulator restarts with the clips of the tuser beat itself. The first tuser after reset publishes 0.
- Gain 0 gives output 0. Offset 0 with gain 1024 is an identity transform.

Test Plan:
1. Offsets 64 all lanes, gains 1024, tuser beat with lanes {100,64,10,1023} -> after 2 cycles O_tdata lanes {36,0,0,959}, O_tuser=1; next tuser publishes O_clip_count=2.
2. Offset 64, gain 1092 (≈1023/959), input 1023 -> output 1023 (saturated: (959*1092+512)>>10 = 1023); input 564 -> 533.
3. Change I_offset_r0 from 64 to 100 mid-frame -> beats keep using 64 until the next accepted tuser beat; that beat uses 100.
4. Hold O_tready=0 for 5 cycles with a continuous input -> I_tready low after the pipeline fills, O_tdata stable. On release, a 100-beat sequence emerges in order with none lost or duplicated.
5. I_bypass=1 latched at tuser, arbitrary data -> O_tdata equals I_tdata delayed 2 cycles; O_clip_count for that frame = 0.
6. Assert I_rst_n=0 for 1 cycle mid-frame with 2 beats in flight -> O_tvalid=0 the next cycle, no stale beats emitted, shadow gain back to 1024.
